wb_port_arbiter: RTL and testbench

WB_PORT_ARBITER -- requirements
Module: wb_port_arbiter

---
 rtl/wb_port_arbiter.sv | 168 ++++++++++++++++
 tb/tb_wb_port_arbiter.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_port_arbiter.sv
// Write-back port arbiter: two requester FIFOs feeding a single registered
// register-file write port under round-robin arbitration.

module wb_port_arbiter_fifo #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 4,
    parameter int DEPTH  = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  push,
    input  logic [ADDR_W-1:0]     push_dest,
    input  logic [DATA_W-1:0]     push_data,
    input  logic                  pop,
    output logic                  full,
    output logic                  empty,
    output logic [ADDR_W-1:0]     head_dest,
    output logic [DATA_W-1:0]     head_data,
    output logic [2**ADDR_W-1:0]  busy
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [ADDR_W-1:0] dest_q [DEPTH];
    logic [DATA_W-1:0] data_q [DEPTH];
    logic [DEPTH-1:0]  vld;
    logic [PW-1:0]     wp;
    logic [PW-1:0]     rp;
    logic [CW-1:0]     cnt;

    // Per-slot valid bits let reg_busy be decoded without walking from rp.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wp  <= '0;
            rp  <= '0;
            cnt <= '0;
            vld <= '0;
        end else begin
            if (pop) begin
                vld[rp] <= 1'b0;
                rp      <= rp + 1'b1;
            end
            if (push) begin
                vld[wp] <= 1'b1;
                wp      <= wp + 1'b1;
            end
            case ({push, pop})
                2'b10:   cnt <= cnt + 1'b1;
                2'b01:   cnt <= cnt - 1'b1;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            dest_q[wp] <= push_dest;
            data_q[wp] <= push_data;
        end
    end

    assign full      = (cnt == CW'(DEPTH));
    assign empty     = (cnt == '0);
    assign head_dest = dest_q[rp];
    assign head_data = data_q[rp];

    always_comb begin
        busy = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            if (vld[i]) busy[dest_q[i]] = 1'b1;
        end
    end
endmodule

module wb_port_arbiter #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 4,
    parameter int DEPTH  = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  a_valid,
    input  logic [ADDR_W-1:0]     a_dest,
    input  logic [DATA_W-1:0]     a_data,
    output logic                  a_ready,
    input  logic                  b_valid,
    input  logic [ADDR_W-1:0]     b_dest,
    input  logic [DATA_W-1:0]     b_data,
    output logic                  b_ready,
    output logic                  wb_en,
    output logic [ADDR_W-1:0]     wb_dest,
    output logic [DATA_W-1:0]     wb_data,
    output logic [2**ADDR_W-1:0]  reg_busy
);
    localparam int NREG = 2**ADDR_W;
    localparam logic [0:0] PTR_A = 1'b0;
    localparam logic [0:0] PTR_B = 1'b1;

    logic              a_full, a_empty, b_full, b_empty;
    logic [ADDR_W-1:0] a_head_dest, b_head_dest;
    logic [DATA_W-1:0] a_head_data, b_head_data;
    logic [NREG-1:0]   a_busy, b_busy, wb_oh;
    logic              grant_a, grant_b;
    logic [0:0]        ptr;

    assign a_ready = !a_full;
    assign b_ready = !b_full;

    wb_port_arbiter_fifo #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH)) u_fifo_a (
        .clk       (clk),
        .rst       (rst),
        .push      (a_valid && a_ready),
        .push_dest (a_dest),
        .push_data (a_data),
        .pop       (grant_a),
        .full      (a_full),
        .empty     (a_empty),
        .head_dest (a_head_dest),
        .head_data (a_head_data),
        .busy      (a_busy)
    );

    wb_port_arbiter_fifo #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH)) u_fifo_b (
        .clk       (clk),
        .rst       (rst),
        .push      (b_valid && b_ready),
        .push_dest (b_dest),
        .push_data (b_data),
        .pop       (grant_b),
        .full      (b_full),
        .empty     (b_empty),
        .head_dest (b_head_dest),
        .head_data (b_head_data),
        .busy      (b_busy)
    );

    // A lone non-empty queue wins regardless of the pointer.
    assign grant_a = !a_empty && (b_empty || (ptr == PTR_A));
    assign grant_b = !b_empty && !grant_a;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr     <= PTR_A;
            wb_en   <= 1'b0;
            wb_dest <= '0;
            wb_data <= '0;
        end else if (grant_a) begin
            ptr     <= PTR_B;
            wb_en   <= 1'b1;
            wb_dest <= a_head_dest;
            wb_data <= a_head_data;
        end else if (grant_b) begin
            ptr     <= PTR_A;
            wb_en   <= 1'b1;
            wb_dest <= b_head_dest;
            wb_data <= b_head_data;
        end else begin
            wb_en   <= 1'b0;
        end
    end

    always_comb begin
        wb_oh = '0;
        if (wb_en) wb_oh[wb_dest] = 1'b1;
    end

    assign reg_busy = a_busy | b_busy | wb_oh;
endmodule

// File: tb/tb_wb_port_arbiter.sv
// Randomised and directed bench for wb_port_arbiter against a queue-based
// reference model of the arbitration rules.

module tb_wb_port_arbiter;
    localparam int DATA_W = 32;
    localparam int ADDR_W = 4;
    localparam int DEPTH  = 2;
    localparam int NREG   = 2**ADDR_W;

    logic              clk = 1'b0;
    logic              rst;
    logic              a_valid, b_valid, a_ready, b_ready;
    logic [ADDR_W-1:0] a_dest, b_dest, wb_dest;
    logic [DATA_W-1:0] a_data, b_data, wb_data;
    logic              wb_en;
    logic [NREG-1:0]   reg_busy;

    always #5 clk = ~clk;

    wb_port_arbiter #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
        .clk      (clk),
        .rst      (rst),
        .a_valid  (a_valid),
        .a_dest   (a_dest),
        .a_data   (a_data),
        .a_ready  (a_ready),
        .b_valid  (b_valid),
        .b_dest   (b_dest),
        .b_data   (b_data),
        .b_ready  (b_ready),
        .wb_en    (wb_en),
        .wb_dest  (wb_dest),
        .wb_data  (wb_data),
        .reg_busy (reg_busy)
    );

    typedef struct {
        logic [ADDR_W-1:0] dest;
        logic [DATA_W-1:0] data;
    } ent_t;

    int n_tests = 0;
    int n_fail  = 0;

    ent_t              qa[$];
    ent_t              qb[$];
    bit                m_ptr_b;
    logic              m_wb_en;
    logic [ADDR_W-1:0] m_wb_dest;
    logic [DATA_W-1:0] m_wb_data;

    task automatic model_reset();
        qa.delete();
        qb.delete();
        m_ptr_b   = 1'b0;
        m_wb_en   = 1'b0;
        m_wb_dest = '0;
        m_wb_data = '0;
    endtask

    // One rising edge: grant from pre-edge queue contents, then accept.
    task automatic model_edge(input logic av, input logic [ADDR_W-1:0] ad, input logic [DATA_W-1:0] adat,
                              input logic bv, input logic [ADDR_W-1:0] bd, input logic [DATA_W-1:0] bdat);
        bit   acc_a, acc_b;
        ent_t e;
        acc_a = av && (qa.size() < DEPTH);
        acc_b = bv && (qb.size() < DEPTH);
        if (qa.size() > 0 && (qb.size() == 0 || !m_ptr_b)) begin
            e = qa.pop_front();
            m_wb_en = 1'b1; m_wb_dest = e.dest; m_wb_data = e.data; m_ptr_b = 1'b1;
        end else if (qb.size() > 0) begin
            e = qb.pop_front();
            m_wb_en = 1'b1; m_wb_dest = e.dest; m_wb_data = e.data; m_ptr_b = 1'b0;
        end else begin
            m_wb_en = 1'b0;
        end
        if (acc_a) begin e.dest = ad; e.data = adat; qa.push_back(e); end
        if (acc_b) begin e.dest = bd; e.data = bdat; qb.push_back(e); end
    endtask

    function automatic logic [NREG-1:0] m_busy();
        logic [NREG-1:0] b = '0;
        foreach (qa[i]) b[qa[i].dest] = 1'b1;
        foreach (qb[i]) b[qb[i].dest] = 1'b1;
        if (m_wb_en) b[m_wb_dest] = 1'b1;
        return b;
    endfunction

    task automatic tick(input logic av, input logic [ADDR_W-1:0] ad, input logic [DATA_W-1:0] adat,
                        input logic bv, input logic [ADDR_W-1:0] bd, input logic [DATA_W-1:0] bdat);
        a_valid = av; a_dest = ad; a_data = adat;
        b_valid = bv; b_dest = bd; b_data = bdat;
        @(posedge clk);
        model_edge(av, ad, adat, bv, bd, bdat);
        #1;
    endtask

    task automatic idle();
        tick(1'b0, '0, '0, 1'b0, '0, '0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        a_valid = 1'b0; b_valid = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        model_reset();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        a_valid = 1'b0; a_dest = '0; a_data = '0;
        b_valid = 1'b0; b_dest = '0; b_data = '0;
        #2;
        n_tests++;
        if ({wb_en, wb_dest, wb_data} !== '0) begin
            n_fail++; $display("FAIL reset_wb: got en=%b dest=%0d data=%h expected all zero", wb_en, wb_dest, wb_data);
        end
        n_tests++;
        if ({a_ready, b_ready} !== 2'b11 || reg_busy !== '0) begin
            n_fail++; $display("FAIL reset_ready_busy: got ready=%b%b busy=%h expected 11 0000", a_ready, b_ready, reg_busy);
        end
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        model_reset();
    endtask

    task automatic test_single();
        tick(1'b1, 4'd3, 32'h1234, 1'b0, '0, '0);
        n_tests++;
        if (wb_en !== 1'b0 || reg_busy !== 16'h0008) begin
            n_fail++; $display("FAIL single_accept: got en=%b busy=%h expected 0 0008", wb_en, reg_busy);
        end
        idle();
        n_tests++;
        if ({wb_en, wb_dest, wb_data} !== {1'b1, 4'd3, 32'h1234} || reg_busy !== 16'h0008) begin
            n_fail++; $display("FAIL single_write: got en=%b dest=%0d data=%h busy=%h expected 1 3 00001234 0008",
                               wb_en, wb_dest, wb_data, reg_busy);
        end
        idle();
        n_tests++;
        if (wb_en !== 1'b0 || reg_busy !== '0 || wb_data !== 32'h1234) begin
            n_fail++; $display("FAIL single_done: got en=%b busy=%h data=%h expected 0 0000 00001234", wb_en, reg_busy, wb_data);
        end
    endtask

    task automatic test_contention();
        logic [ADDR_W-1:0] exp_d [5] = '{4'd1, 4'd2, 4'd7, 4'd2, 4'd1};
        logic [DATA_W-1:0] exp_v [5] = '{32'hA, 32'hB, 32'hC, 32'hB2, 32'hA2};
        do_reset();
        tick(1'b1, 4'd1, 32'hA, 1'b1, 4'd2, 32'hB);
        for (int k = 0; k < 5; k++) begin
            if (k == 1)      tick(1'b1, 4'd7, 32'hC, 1'b0, '0, '0);
            else if (k == 2) tick(1'b1, 4'd1, 32'hA2, 1'b1, 4'd2, 32'hB2);
            else             idle();
            n_tests++;
            if ({wb_en, wb_dest, wb_data} !== {1'b1, exp_d[k], exp_v[k]}) begin
                n_fail++; $display("FAIL contention_%0d: got en=%b dest=%0d data=%h expected 1 %0d %h",
                                   k, wb_en, wb_dest, wb_data, exp_d[k], exp_v[k]);
            end
        end
        idle();
    endtask

    task automatic test_same_reg();
        do_reset();
        tick(1'b1, 4'd5, 32'h11, 1'b1, 4'd5, 32'h22);
        idle();
        n_tests++;
        if ({wb_en, wb_dest, wb_data} !== {1'b1, 4'd5, 32'h11} || reg_busy !== 16'h0020) begin
            n_fail++; $display("FAIL same_reg_first: got en=%b dest=%0d data=%h busy=%h expected 1 5 00000011 0020",
                               wb_en, wb_dest, wb_data, reg_busy);
        end
        idle();
        n_tests++;
        if ({wb_en, wb_dest, wb_data} !== {1'b1, 4'd5, 32'h22} || reg_busy !== 16'h0020) begin
            n_fail++; $display("FAIL same_reg_second: got en=%b dest=%0d data=%h busy=%h expected 1 5 00000022 0020",
                               wb_en, wb_dest, wb_data, reg_busy);
        end
        idle();
        n_tests++;
        if (wb_en !== 1'b0 || reg_busy !== '0) begin
            n_fail++; $display("FAIL same_reg_clear: got en=%b busy=%h expected 0 0000", wb_en, reg_busy);
        end
    endtask

    task automatic test_full();
        do_reset();
        for (int i = 0; i < 14; i++) begin
            n_tests++;
            if ({a_ready, b_ready} !== {qa.size() < DEPTH, qb.size() < DEPTH}) begin
                n_fail++; $display("FAIL full_ready_%0d: got %b%b expected %b%b", i, a_ready, b_ready,
                                   qa.size() < DEPTH, qb.size() < DEPTH);
            end
            if (i < 8) tick(1'b1, 4'($urandom_range(0, 15)), $urandom, 1'b1, 4'(i), i);
            else       idle();
            if (i == 1) begin
                n_tests++;
                if (b_ready !== 1'b0) begin
                    n_fail++; $display("FAIL full_b_ready_low: got %b expected 0", b_ready);
                end
            end
            n_tests++;
            if ({wb_en, wb_dest, wb_data} !== {m_wb_en, m_wb_dest, m_wb_data} || reg_busy !== m_busy()) begin
                n_fail++; $display("FAIL full_port_%0d: got en=%b dest=%0d data=%h busy=%h expected %b %0d %h %h",
                                   i, wb_en, wb_dest, wb_data, reg_busy, m_wb_en, m_wb_dest, m_wb_data, m_busy());
            end
        end
    endtask

    task automatic test_random();
        do_reset();
        for (int i = 0; i < 400; i++) begin
            n_tests++;
            if ({a_ready, b_ready} !== {qa.size() < DEPTH, qb.size() < DEPTH}) begin
                n_fail++; $display("FAIL rand_ready_%0d: got %b%b expected %b%b", i, a_ready, b_ready,
                                   qa.size() < DEPTH, qb.size() < DEPTH);
            end
            tick($urandom_range(0, 99) < 60, 4'($urandom), $urandom,
                 $urandom_range(0, 99) < 45, 4'($urandom), $urandom);
            n_tests++;
            if ({wb_en, wb_dest, wb_data} !== {m_wb_en, m_wb_dest, m_wb_data} || reg_busy !== m_busy()) begin
                n_fail++; $display("FAIL rand_port_%0d: got en=%b dest=%0d data=%h busy=%h expected %b %0d %h %h",
                                   i, wb_en, wb_dest, wb_data, reg_busy, m_wb_en, m_wb_dest, m_wb_data, m_busy());
            end
        end
    endtask

    task automatic test_midflight_reset();
        do_reset();
        tick(1'b1, 4'd1, 32'h1, 1'b1, 4'd2, 32'h2);
        tick(1'b1, 4'd3, 32'h3, 1'b1, 4'd4, 32'h4);
        #2;
        rst = 1'b1;
        a_valid = 1'b0; b_valid = 1'b0;
        #1;
        n_tests++;
        if (wb_en !== 1'b0 || reg_busy !== '0 || {a_ready, b_ready} !== 2'b11) begin
            n_fail++; $display("FAIL midreset_now: got en=%b busy=%h ready=%b%b expected 0 0000 11",
                               wb_en, reg_busy, a_ready, b_ready);
        end
        #1;
        rst = 1'b0;
        model_reset();
        for (int i = 0; i < 5; i++) begin
            idle();
            n_tests++;
            if (wb_en !== 1'b0 || reg_busy !== '0) begin
                n_fail++; $display("FAIL midreset_after_%0d: got en=%b busy=%h expected 0 0000", i, wb_en, reg_busy);
            end
        end
    endtask

    task automatic test_idle();
        do_reset();
        tick(1'b0, '0, '0, 1'b1, 4'd9, 32'hDEAD_BEEF);
        idle();
        for (int i = 0; i < 10; i++) begin
            idle();
            n_tests++;
            if ({wb_en, wb_dest, wb_data} !== {1'b0, 4'd9, 32'hDEAD_BEEF}) begin
                n_fail++; $display("FAIL idle_%0d: got en=%b dest=%0d data=%h expected 0 9 deadbeef",
                                   i, wb_en, wb_dest, wb_data);
            end
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_contention();
        test_same_reg();
        test_full();
        test_random();
        test_midflight_reset();
        test_idle();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
